// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port: a registered output, a synchronized input with
// change-detect interrupt, and a saturating change counter, sharing the processor bus with data memory.
module io_port_ctrl #(
   parameter int                NBITS     = 8,
   parameter logic [NBITS-3:0]  DATA_ADDR = {(NBITS-2){1'b1}},
   parameter logic [NBITS-3:0]  STAT_ADDR = DATA_ADDR - (NBITS-2)'(1),
   parameter logic [NBITS-3:0]  CNT_ADDR  = DATA_ADDR - (NBITS-2)'(2)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NBITS-3:0]  addr,
   input  logic [NBITS-1:0]  wdata,
   input  logic              wren,
   input  logic [NBITS-1:0]  mem_q,
   output logic [NBITS-1:0]  rdata,
   output logic              mem_wren,
   input  logic [NBITS-1:0]  entrada,
   output logic [NBITS-1:0]  saida,
   output logic              interrupt
);

   logic              sel_data;
   logic              sel_stat;
   logic              sel_cnt;
   logic              io;
   logic              wr_data;
   logic              wr_stat;
   logic              wr_cnt;
   logic [NBITS-1:0]  sync1;
   logic [NBITS-1:0]  sync2;
   logic [NBITS-1:0]  prev;
   logic              change;
   logic              event_hit;
   logic              pending;
   logic              enable;
   logic [NBITS-1:0]  count;

   assign sel_data = (addr == DATA_ADDR);
   assign sel_stat = (addr == STAT_ADDR);
   assign sel_cnt  = (addr == CNT_ADDR);
   assign io       = sel_data | sel_stat | sel_cnt;

   assign mem_wren = wren & ~io;
   assign wr_data  = wren & sel_data;
   assign wr_stat  = wren & sel_stat;
   assign wr_cnt   = wren & sel_cnt;

   assign change    = (sync2 != prev);
   assign event_hit = enable & change;

   // entrada is asynchronous; nothing downstream looks at it before sync2.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prev  <= '0;
      end else begin
         sync1 <= entrada;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         saida <= '0;
      end else if (wr_data) begin
         saida <= wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         enable <= 1'b0;
      end else if (wr_stat) begin
         enable <= wdata[1];
      end
   end

   // A new event beats a same-cycle write-1-to-clear so no change is lost.
   always_ff @(posedge clock) begin
      if (reset) begin
         pending <= 1'b0;
      end else if (event_hit) begin
         pending <= 1'b1;
      end else if (wr_stat && wdata[0]) begin
         pending <= 1'b0;
      end
   end

   // Clearing beats a same-cycle increment; the count sticks at all-ones.
   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
      end else if (wr_cnt) begin
         count <= '0;
      end else if (event_hit && (count != {NBITS{1'b1}})) begin
         count <= count + NBITS'(1);
      end
   end

   assign interrupt = pending & enable;

   always_comb begin
      rdata = mem_q;
      if (sel_data) begin
         rdata = sync2;
      end else if (sel_stat) begin
         rdata = {{(NBITS-2){1'b0}}, enable, pending};
      end else if (sel_cnt) begin
         rdata = count;
      end
   end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter NBITS, default 8, SHALL set the data width; word address width is NBITS-2 (bits NBITS-1:2).
REQ-002 Parameter DATA_ADDR, default all-ones word address (6'h3F at NBITS=8), SHALL select the data port.
REQ-003 Parameter STAT_ADDR, default DATA_ADDR-1 (6'h3E), SHALL select the status/control register.
REQ-004 Parameter CNT_ADDR, default DATA_ADDR-2 (6'h3D), SHALL select the change counter.
REQ-005 clock  input  1  system clock, all state updates on its rising edge.
REQ-006 reset  input  1  reset, synchronous, active-high.
REQ-007 addr  input  NBITS-2  processor word address, bits NBITS-1:2.
REQ-008 wdata  input  NBITS  processor write data.
REQ-009 wren  input  1  processor write command.
REQ-010 mem_q  input  NBITS  read data from data memory.
REQ-011 rdata  output  NBITS  read data returned to processor.
REQ-012 mem_wren  output  1  write enable forwarded to data memory.
REQ-013 entrada  input  NBITS  asynchronous external input port.
REQ-014 saida  output  NBITS  registered external output port.
REQ-015 interrupt  output  1  interrupt request to processor.

Function
REQ-016 io SHALL be 1 iff addr equals DATA_ADDR, STAT_ADDR or CNT_ADDR; every other address is memory.
REQ-017 mem_wren SHALL equal wren & ~io (combinational); I/O writes never reach memory.
REQ-018 entrada SHALL pass through two flip-flop stages (sync1, sync2) before any use.
REQ-019 prev SHALL load sync2 every cycle; change = (sync2 != prev), combinational.
REQ-020 If enable=1 and change=1, pending SHALL be set on the next edge.
REQ-021 If enable=1 and change=1, count SHALL increment on the next edge, saturating at 2^NBITS-1 (no wrap).
REQ-022 With enable=0, changes SHALL affect neither pending nor count; prev still tracks sync2.
REQ-023 Latency: entrada stable new value before edge k -> sync2 at k+1 -> pending and interrupt high after edge k+2.
REQ-024 interrupt SHALL equal pending & enable (pending is a register; no combinational path from entrada).
REQ-025 Write to DATA_ADDR SHALL load saida <= wdata on that edge.
REQ-026 Write to STAT_ADDR SHALL load enable <= wdata[1]; wdata[0]=1 SHALL clear pending (write-1-to-clear); wdata[0]=0 leaves pending.
REQ-027 Same-cycle set (REQ-020) and clear (REQ-026) SHALL leave pending=1 (set wins).
REQ-028 Write to CNT_ADDR SHALL clear count to 0 regardless of wdata; a same-cycle increment SHALL be dropped (clear wins).
REQ-029 rdata SHALL be combinational: DATA_ADDR -> sync2; STAT_ADDR -> {zeros, enable, pending} (bit1 enable, bit0 pending); CNT_ADDR -> count; otherwise mem_q.
REQ-030 Reading any I/O address SHALL have no side effects.

Reset
REQ-031 While reset=1 at an edge: saida, sync1, sync2, prev, pending, enable, count SHALL all become 0; interrupt therefore 0.
REQ-032 Reset SHALL override any simultaneous write or change event.
REQ-033 A nonzero entrada held across reset deassertion SHALL register as one change 2 edges later, counted only if enable=1 by then.

Verification
REQ-034 Reset, write 8'hA5 to 6'h3F -> saida=8'hA5 after that edge; mem_wren=0 during the write.
REQ-035 Write 8'h02 to 6'h3E, toggle entrada 8'h00->8'h01 before edge k -> interrupt=1 after edge k+2; read 6'h3E -> 8'h03; read 6'h3D -> 8'h01.
REQ-036 Pending set, write 8'h03 to 6'h3E -> pending=0, interrupt=0, enable stays 1; with a change arriving that same cycle -> pending stays 1.
REQ-037 enable=0, toggle entrada 10 times -> interrupt=0, count=0; read 6'h3F returns synchronized entrada.
REQ-038 enable=1, 300 toggles at NBITS=8 -> count=8'hFF (saturated); write to 6'h3D -> count=0.
REQ-039 Write 8'h5A to 6'h3C, read 6'h3C -> mem_wren=1 on write, rdata=mem_q; assert reset mid-sequence with pending=1 -> all outputs 0 next edge.
